// File: rtl/beat_sequencer.sv
// Record/playback sequencer: captures one keyboard note per beat tick into a
// small note RAM, then replays the stored sequence one entry per tick.
module beat_sequencer #(
  parameter int NOTE_W   = 5,
  parameter int DEPTH    = 256,
  parameter int TICK_DIV = 500000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ram_load,
  input  logic                        keyboard_record,
  input  logic                        rd_load_from,
  input  logic                        play_req,
  input  logic [NOTE_W-1:0]           key_note,
  output logic [NOTE_W-1:0]           note_out,
  output logic [$clog2(DEPTH):0]      rec_len,
  output logic                        full,
  output logic                        playing,
  output logic                        done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  // One bit wider than the RAM index so a full sequence can reach rec_len == DEPTH.
  logic [AW:0]       raddr_q, raddr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [AW:0]       rec_len_q, rec_len_d;
  logic              full_q, full_d;
  logic              done_q, done_d;
  logic              mem_we;
  logic              tick;
  logic              rec_start;

  logic [NOTE_W-1:0] mem [DEPTH];

  assign rec_start = ram_load & keyboard_record;
  assign tick      = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    rec_len_d = rec_len_q;
    full_d    = full_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    note_d    = rd_load_from ? key_note : '0;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rec_start) begin
          waddr_d   = '0;
          rec_len_d = '0;
          full_d    = 1'b0;
          state_d   = S_RECORD;
        end else if (play_req && !rd_load_from && rec_len_q != '0) begin
          raddr_d = '0;
          state_d = S_PLAY;
        end
      end
      S_RECORD: begin
        // Losing rec_start wins over a coincident tick: the partial beat is dropped.
        if (!rec_start) begin
          state_d = S_IDLE;
        end else if (tick && !full_q) begin
          mem_we    = 1'b1;
          waddr_d   = waddr_q + 1'b1;
          rec_len_d = {1'b0, waddr_q} + 1'b1;
          if (waddr_q == AW'(DEPTH - 1)) full_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (!play_req || rd_load_from || rec_start) begin
          state_d = S_IDLE;
        end else begin
          note_d = note_q;
          if (tick) begin
            if (raddr_q < rec_len_q) begin
              note_d  = mem[raddr_q[AW-1:0]];
              raddr_d = raddr_q + 1'b1;
            end else begin
              done_d  = 1'b1;
              note_d  = '0;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The beat counter restarts on every state entry.
    if (state_d != state_q) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      waddr_q   <= '0;
      raddr_q   <= '0;
      cnt_q     <= '0;
      note_q    <= '0;
      rec_len_q <= '0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      cnt_q     <= cnt_d;
      note_q    <= note_d;
      rec_len_q <= rec_len_d;
      full_q    <= full_d;
      done_q    <= done_d;
    end
  end

  // NOTE: the note RAM is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr_q] <= key_note;
  end

  assign note_out = note_q;
  assign rec_len  = rec_len_q;
  assign full     = full_q;
  assign playing  = (state_q == S_PLAY);
  assign done     = done_q;

endmodule
